// File: rtl/alu_result_stage.sv
// alu_result_stage: EX->MEM pipeline stage directly downstream of the ALU.
// Holds ALU results in a 2-entry skid buffer (head H, skid S) with
// valid/ready handshakes on both sides. It also resolves zero-based
// branches and provides a forwarding tap for decode/issue.
//
// Optional feature macro: ALU_OVF_TRAP_EN
//   defined   : an accepted entry with overflow & wb_en has its write-back
//               suppressed. trap pulses for one cycle and trap_count
//               increments, saturating at all-ones.
//   undefined : overflow is only carried to out_overflow; trap/trap_count are 0.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   flush             sync squash of all held entries (overrides accept)
//   in_valid/in_ready upstream handshake; in_ready is registered
//   in_result, in_overflow, in_zero, in_rd, in_wb_en, in_is_branch
//                     ALU result payload
//   out_valid/out_ready downstream handshake
//   out_result, out_rd, out_wb_en, out_overflow
//                     head entry payload, driven from flops
//   branch_taken      head is a branch compare with zero result
//   fwd_valid/fwd_rd/fwd_data
//                     forwarding tap from the head entry
//   trap, trap_count  overflow trap pulse and saturating trap counter
module alu_result_stage #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RD_W       = 5,
  parameter int unsigned TRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_result,
  input  logic                  in_overflow,
  input  logic                  in_zero,
  input  logic [RD_W-1:0]       in_rd,
  input  logic                  in_wb_en,
  input  logic                  in_is_branch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_result,
  output logic [RD_W-1:0]       out_rd,
  output logic                  out_wb_en,
  output logic                  out_overflow,
  output logic                  branch_taken,
  output logic                  fwd_valid,
  output logic [RD_W-1:0]       fwd_rd,
  output logic [WIDTH-1:0]      fwd_data,
  output logic                  trap,
  output logic [TRAP_CNT_W-1:0] trap_count
);

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_EMPTY = 2'd0;
  localparam logic [ST_W-1:0] ST_ONE   = 2'd1;
  localparam logic [ST_W-1:0] ST_TWO   = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             zero;
    logic [RD_W-1:0]  rd;
    logic             wb_en;
    logic             is_branch;
  } entry_t;

  logic [ST_W-1:0] state_q, state_d;
  entry_t          h_q, h_d;
  entry_t          s_q, s_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  entry_t          in_entry;
  logic            accept;
  logic            drain;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  // Incoming payload; with the trap feature an overflowing write is suppressed.
  always_comb begin
    in_entry.result    = in_result;
    in_entry.overflow  = in_overflow;
    in_entry.zero      = in_zero;
    in_entry.rd        = in_rd;
    in_entry.is_branch = in_is_branch;
`ifdef ALU_OVF_TRAP_EN
    in_entry.wb_en     = in_wb_en & ~in_overflow;
`else
    in_entry.wb_en     = in_wb_en;
`endif
  end

  // Occupancy FSM and data movement between H and S.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          h_d     = in_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          h_d = in_entry;
        end else if (accept) begin
          s_d     = in_entry;
          state_d = ST_TWO;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          h_d     = s_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over any same-cycle accept; data may stay stale.
    if (flush) begin
      state_d = ST_EMPTY;
    end
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      h_q         <= '0;
      s_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      s_q         <= s_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_result   = h_q.result;
  assign out_rd       = h_q.rd;
  assign out_wb_en    = h_q.wb_en;
  assign out_overflow = h_q.overflow;

  // Head-derived side outputs; gated by out_valid so stale data never leaks.
  assign branch_taken = out_valid_q & h_q.is_branch & h_q.zero;
  assign fwd_valid    = out_valid_q & h_q.wb_en & (h_q.rd != RD_W'(0));
  assign fwd_rd       = h_q.rd;
  assign fwd_data     = h_q.result;

`ifdef ALU_OVF_TRAP_EN
  logic                  trap_q, trap_d;
  logic [TRAP_CNT_W-1:0] trap_count_q, trap_count_d;

  // A trap is taken on accept, independent of a same-cycle flush.
  always_comb begin
    trap_d       = accept & in_overflow & in_wb_en;
    trap_count_d = trap_count_q;
    if (trap_d && (trap_count_q != {TRAP_CNT_W{1'b1}})) begin
      trap_count_d = trap_count_q + TRAP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q       <= 1'b0;
      trap_count_q <= '0;
    end else begin
      trap_q       <= trap_d;
      trap_count_q <= trap_count_d;
    end
  end

  assign trap       = trap_q;
  assign trap_count = trap_count_q;
`else
  assign trap       = 1'b0;
  assign trap_count = '0;
`endif

endmodule
